ctrl_pipe_chain: RTL

- Parametrised multi-stage control pipeline register chain; successor to the single-stage ID/EX control register.
- Carries a packed control word plus a valid bit through STAGES back-to-back stages, e.g. D→E→M→W.
- Per-stage stall (hold) and flush (kill).
- Stalls propagate automatically upstream; bubbles are inserted automatically downstream.
- Saturating counters for killed entries and retire-stage bubbles feed hazard-unit debug and perf logic.

---
 rtl/ctrl_pipe_chain_pkg.sv | 27 ++
 rtl/ctrl_pipe_chain_if.sv | 27 ++
 rtl/ctrl_pipe_chain_stage.sv | 34 +++
 rtl/ctrl_pipe_chain.sv | 81 ++++++++
 4 files changed

// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared types and helpers for the control pipeline chain.
// Pure functions only: no state and no timing.
package ctrl_pipe_pkg;

    localparam int MAX_STAGES = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Clamps at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int          w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, cnt} + {1'b0, inc};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Bundle of the control-pipeline inputs and registered stage/counter outputs.
// Master drives decode, stall, flush and clear; slave is the pipeline.
interface ctrl_pipe_chain_if #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
);
    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic                    cnt_clr;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic [STAGES-1:0]       stage_valid;
    logic [CNT_W-1:0]        kill_cnt;
    logic [CNT_W-1:0]        bubble_cnt;

    modport master (
        output in_data, in_valid, stall, flush, cnt_clr,
        input  stage_data, stage_valid, kill_cnt, bubble_cnt
    );

    modport slave (
        input  in_data, in_valid, stall, flush, cnt_clr,
        output stage_data, stage_valid, kill_cnt, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe_chain_stage.sv
// One control register stage: flush > hold > bubble > load.
// One cycle latency; hold comes from the chain's effective stall.
module ctrl_pipe_stage #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q  <= RESET_VAL;
            qv <= 1'b0;
        end else if (hold) begin
            q  <= q;
            qv <= qv;
        end else if (bubble) begin
            q  <= RESET_VAL;
            qv <= 1'b0;
        end else begin
            q  <= d;
            qv <= dv;
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Multi-stage control register chain with stall/flush and saturating perf counters.
// STAGES cycles in-to-out; a stall holds its stage and every stage upstream of it.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               STAGES    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    ctrl_pipe_chain_if.slave   bus
);

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] es;
    logic [7:0]        kill_vec;
    logic [CNT_W-1:0]  kill_q;
    logic [CNT_W-1:0]  bubble_q;

    // Effective stall: OR of own stall and every downstream stall.
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc   = acc | bus.stall[i];
            es[i] = acc;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            ctrl_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .flush  (bus.flush[0]),
                .hold   (es[0]),
                .bubble (1'b0),
                .d      (bus.in_data),
                .dv     (bus.in_valid),
                .q      (data_q[0]),
                .qv     (valid_q[0])
            );
        end else begin : g_rest
            ctrl_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .flush  (bus.flush[g]),
                .hold   (es[g]),
                .bubble (es[g-1]),
                .d      (data_q[g-1]),
                .dv     (valid_q[g-1]),
                .q      (data_q[g]),
                .qv     (valid_q[g])
            );
        end
        assign bus.stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    always_comb begin
        kill_vec              = '0;
        kill_vec[STAGES-1:0]  = bus.flush & valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.cnt_clr) begin
            kill_q   <= '0;
            bubble_q <= '0;
        end else begin
            kill_q   <= CNT_W'(sat_add(32'(kill_q), 32'(popcount8(kill_vec)), CNT_W));
            bubble_q <= CNT_W'(sat_add(32'(bubble_q), 32'(!valid_q[STAGES-1]), CNT_W));
        end
    end

    assign bus.stage_valid = valid_q;
    assign bus.kill_cnt    = kill_q;
    assign bus.bubble_cnt  = bubble_q;

endmodule
